// File: rtl/p1v_pin_pkg.sv
// Shared definitions for the Propeller pin-input conditioning path: pin count,
// the pin vector type, and the legal bounds of the conditioner's parameters.
package p1v_pin_pkg;

    localparam int NUMPINS = 32;

    typedef logic [NUMPINS-1:0] pin_vec_t;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;
    localparam int PIPELINE_STAGES_MIN = 0;
    localparam int PIPELINE_STAGES_MAX = 4;
    localparam int FILTER_LEN_MIN      = 1;
    localparam int FILTER_LEN_MAX      = 255;

endpackage

// File: rtl/pin_deglitch.sv
// Single-bit deglitch filter: a new level is accepted only after it has been
// seen on the synchronized input for FILTER_LEN consecutive cycles.
module pin_deglitch
    import p1v_pin_pkg::*;
#(
    parameter int   FILTER_LEN = 4,
    parameter logic INIT_BIT   = 1'b0
) (
    input  logic pllX16,
    input  logic res,
    input  logic sync_i,
    output logic filt_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // The counter only advances while the input disagrees with the held level,
    // and is cleared on acceptance, so it tops out at FILTER_LEN-1.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_i == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pllX16) begin
        if (res) begin
            cnt_q  <= '0;
            filt_q <= INIT_BIT;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/pin_input_conditioner.sv
// Synchronizes, optionally deglitches (PIN_DEGLITCH_EN), retimes and edge-detects
// the 32 pad inputs; pins driven by the Propeller read back pin_out directly.
module pin_input_conditioner
    import p1v_pin_pkg::*;
#(
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 PIPELINE_STAGES = 2,
    parameter int                 FILTER_LEN      = 4,
    parameter logic [NUMPINS-1:0] INIT            = '0
) (
    input  logic               pllX16,
    input  logic               res,
    input  logic [NUMPINS-1:0] pin_in,
    input  logic [NUMPINS-1:0] pin_out,
    input  logic [NUMPINS-1:0] pin_dir,
    output logic [NUMPINS-1:0] prop_input_bus,
    output logic [NUMPINS-1:0] edge_rise,
    output logic [NUMPINS-1:0] edge_fall
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("pin_input_conditioner: SYNC_STAGES out of range");
    end
    if (PIPELINE_STAGES < PIPELINE_STAGES_MIN || PIPELINE_STAGES > PIPELINE_STAGES_MAX) begin : g_bad_pipe
        $error("pin_input_conditioner: PIPELINE_STAGES out of range");
    end
    if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filt
        $error("pin_input_conditioner: FILTER_LEN out of range");
    end

    (* ASYNC_REG = "TRUE" *) pin_vec_t sync_q [SYNC_STAGES];
    pin_vec_t filt;
    pin_vec_t cond;
    pin_vec_t cond_q;
    pin_vec_t rise_q, rise_d;
    pin_vec_t fall_q, fall_d;

    // Plain flop chain from the pads; nothing may sit between stages.
    always_ff @(posedge pllX16) begin
        if (res) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INIT;
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef PIN_DEGLITCH_EN
    for (genvar i = 0; i < NUMPINS; i++) begin : g_filt
        pin_deglitch #(
            .FILTER_LEN (FILTER_LEN),
            .INIT_BIT   (INIT[i])
        ) u_deglitch (
            .pllX16 (pllX16),
            .res    (res),
            .sync_i (sync_q[SYNC_STAGES-1][i]),
            .filt_o (filt[i])
        );
    end
`else
    assign filt = sync_q[SYNC_STAGES-1];
`endif

    if (PIPELINE_STAGES == 0) begin : g_nopipe
        assign cond = filt;
    end else begin : g_pipe
        pin_vec_t pipe_q [PIPELINE_STAGES];

        always_ff @(posedge pllX16) begin
            if (res) begin
                for (int s = 0; s < PIPELINE_STAGES; s++) pipe_q[s] <= INIT;
            end else begin
                pipe_q[0] <= filt;
                for (int s = 1; s < PIPELINE_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
            end
        end

        assign cond = pipe_q[PIPELINE_STAGES-1];
    end

    // cond_q resets to INIT alongside the data path, so leaving reset never looks like an edge.
    assign rise_d = cond & ~cond_q;
    assign fall_d = ~cond & cond_q;

    always_ff @(posedge pllX16) begin
        if (res) begin
            cond_q <= INIT;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cond_q <= cond;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign edge_rise      = rise_q;
    assign edge_fall      = fall_q;
    assign prop_input_bus = (pin_dir & pin_out) | (~pin_dir & cond);

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner: default instance plus a
// SYNC_STAGES=3 / PIPELINE_STAGES=0 / INIT=all-ones instance.
module tb_pin_input_conditioner;
    import p1v_pin_pkg::*;

`ifdef PIN_DEGLITCH_EN
    localparam int LAT  = 8;
    localparam int LAT2 = 7;
`else
    localparam int LAT  = 4;
    localparam int LAT2 = 3;
`endif

    typedef struct packed {
        logic [31:0] dir;
        logic [31:0] out;
        logic [31:0] expBus;
    } vec_t;

    logic     clock = 1'b0;
    logic     reset = 1'b1;
    pin_vec_t pinIn   = '0;
    pin_vec_t pinOut  = '0;
    pin_vec_t pinDir  = '0;
    pin_vec_t pinIn2  = '1;
    pin_vec_t zeroVec = '0;
    pin_vec_t busOut, riseOut, fallOut;
    pin_vec_t busOut2, riseOut2, fallOut2;
    pin_vec_t accRise  = '0;
    pin_vec_t accFall  = '0;
    pin_vec_t accEdge2 = '0;
    int       assertCount = 0;
    int       failCount   = 0;
    vec_t     vecs [6];

    pin_input_conditioner dut (
        .pllX16         (clock),
        .res            (reset),
        .pin_in         (pinIn),
        .pin_out        (pinOut),
        .pin_dir        (pinDir),
        .prop_input_bus (busOut),
        .edge_rise      (riseOut),
        .edge_fall      (fallOut)
    );

    pin_input_conditioner #(
        .SYNC_STAGES     (3),
        .PIPELINE_STAGES (0),
        .INIT            (32'hFFFF_FFFF)
    ) dut2 (
        .pllX16         (clock),
        .res            (reset),
        .pin_in         (pinIn2),
        .pin_out        (zeroVec),
        .pin_dir        (zeroVec),
        .prop_input_bus (busOut2),
        .edge_rise      (riseOut2),
        .edge_fall      (fallOut2)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        accRise  = accRise | riseOut;
        accFall  = accFall | fallOut;
        accEdge2 = accEdge2 | riseOut2 | fallOut2;
    endtask

    task automatic applyStimulus(input logic [31:0] dir, input logic [31:0] out);
        pinDir = dir;
        pinOut = out;
        #1;
    endtask

    task automatic waitBus(input int bitIdx, input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busOut[bitIdx] !== val && n < 40);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0F0F_00F0};
        vecs[1] = '{32'hFFFF_0000, 32'hA5A5_0000, 32'hA5A5_00F0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0F0F_FFFF};
        vecs[4] = '{32'h00FF_00FF, 32'h0000_0000, 32'h0F00_0000};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0F0F_00F0};

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checkOutput("reset bus", busOut, 32'h0);
        checkOutput("reset rise", riseOut, 32'h0);
        checkOutput("reset fall", fallOut, 32'h0);
        checkOutput("reset bus2 INIT", busOut2, 32'hFFFF_FFFF);
        tick();
        accRise  = '0;
        accFall  = '0;
        accEdge2 = '0;

        // bit 0 rising through the conditioned path
        pinIn = 32'h0000_0001;
        waitBus(0, 1'b1, n);
        checkOutput("rise latency", n, LAT);
        tick();
        checkOutput("rise pulse", riseOut, 32'h0000_0001);
        tick();
        checkOutput("rise pulse width", riseOut, 32'h0);
        checkOutput("no fall during rise", accFall, 32'h0);

        // bit 0 falling
        accRise = '0;
        pinIn = 32'h0;
        waitBus(0, 1'b0, n);
        checkOutput("fall latency", n, LAT);
        tick();
        checkOutput("fall pulse", fallOut, 32'h0000_0001);
        tick();
        checkOutput("fall pulse width", fallOut, 32'h0);
        checkOutput("no rise during fall", accRise, 32'h0);

        // short pulses on bit 5: 3 cycles is rejected only by the filter
        for (int w = 3; w <= 4; w++) begin
            int  firstHigh, highCnt, riseCnt, fallCnt;
            bit  expPass;
            firstHigh = 0;
            highCnt   = 0;
            riseCnt   = 0;
            fallCnt   = 0;
`ifdef PIN_DEGLITCH_EN
            expPass = (w >= 4);
`else
            expPass = 1'b1;
`endif
            pinIn[5] = 1'b1;
            for (int t = 1; t <= 30; t++) begin
                tick();
                if (t == w) pinIn[5] = 1'b0;
                if (busOut[5]) begin
                    highCnt++;
                    if (firstHigh == 0) firstHigh = t;
                end
                riseCnt += int'(riseOut[5]);
                fallCnt += int'(fallOut[5]);
            end
            checkOutput($sformatf("pulse%0d high cycles", w), highCnt, expPass ? w : 0);
            checkOutput($sformatf("pulse%0d first high", w), firstHigh, expPass ? LAT : 0);
            checkOutput($sformatf("pulse%0d rise count", w), riseCnt, expPass ? 1 : 0);
            checkOutput($sformatf("pulse%0d fall count", w), fallCnt, expPass ? 1 : 0);
        end

        // bypass table with a stable conditioned pattern underneath
        pinIn = 32'h0F0F_00F0;
        repeat (20) tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].dir, vecs[i].out);
            checkOutput($sformatf("bypass vec%0d bus", i), busOut, vecs[i].expBus);
            checkOutput($sformatf("bypass vec%0d rise", i), riseOut, 32'h0);
            checkOutput($sformatf("bypass vec%0d fall", i), fallOut, 32'h0);
            tick();
        end
        applyStimulus(32'h0, 32'h0);

        // INIT all-ones instance: no edges while pad stays high, then a toggle on bit 31
        checkOutput("dut2 no edges while high", accEdge2, 32'h0);
        checkOutput("dut2 bus held high", busOut2, 32'hFFFF_FFFF);
        pinIn2[31] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busOut2[31] !== 1'b0 && n < 40);
        checkOutput("dut2 toggle latency", n, LAT2);
        tick();
        checkOutput("dut2 fall pulse", fallOut2, 32'h8000_0000);

        // reset in the middle of filtering all-ones
        pinIn = 32'h0;
        repeat (20) tick();
        pinIn = 32'hFFFF_FFFF;
        repeat (4) tick();
        reset   = 1'b1;
        accRise = '0;
        accFall = '0;
        tick();
        checkOutput("bus during reset", busOut, 32'h0);
        tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busOut !== 32'hFFFF_FFFF && n < 40);
        checkOutput("post-reset latency", n, LAT);
        checkOutput("no rise around reset", accRise, 32'h0);
        checkOutput("no fall around reset", accFall, 32'h0);
        tick();
        checkOutput("post-reset rise", riseOut, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pin_input_conditioner.md
# pin_input_conditioner

Conditions the 32 asynchronous Propeller I/O pin inputs before they reach the `p1v` core's `pin_in` bus. It sits between the board top level's pad connections and `p1v`, in the `pllX16` (80 MHz) domain. Per bit, it provides:

- a multi-flop synchronizer;
- an optional deglitch filter;
- a retiming pipeline;
- single-cycle edge pulses;
- a direction-based bypass, so that pins the Propeller drives read back their own output value immediately.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — synchronizer depth; legal range 2..4.
- `PIPELINE_STAGES`, 2 — retiming flops after sync/filter; legal range 0..4.
- `FILTER_LEN`, 4 — consecutive cycles a changed level must persist to pass the filter; legal range 1..255.
- `INIT`, 32'b0 — reset value of every per-bit data register.

Ports:
- `pllX16` input 1 — single clock. All logic is clocked on its rising edge.
- `res` input 1 — synchronous, active-high reset, sampled on `pllX16`.
- `pin_in` input 32 — raw pad levels, asynchronous to `pllX16`.
- `pin_out` input 32 — Propeller output values, in the `pllX16` domain.
- `pin_dir` input 32 — Propeller direction bits; 1 = output.
- `prop_input_bus` output 32 — value presented to `p1v` `pin_in`.
- `edge_rise` output 32 — one-cycle pulse on each conditioned 0→1 transition.
- `edge_fall` output 32 — one-cycle pulse on each conditioned 1→0 transition.

## Operation
- Synchronizer: `SYNC_STAGES` flops per bit, no logic between stages. Each flop carries ASYNC_REG and is placed in a shared slice.
- Deglitch filter (only when compiled in; see Configuration). Per bit it keeps a held level `filt` and a counter `cnt` of width `$clog2(FILTER_LEN+1)`. On each edge:
  - If `sync == filt`: `cnt <= 0`.
  - Else if `cnt == FILTER_LEN-1`: `filt <= sync` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - The counter saturates by construction and never wraps.
- Pipeline: `PIPELINE_STAGES` plain flops. The last stage is `cond`. When `PIPELINE_STAGES` = 0, `cond` is the filter or synchronizer output directly.
- Edge detect: `cond_q` is registered from `cond`. `edge_rise` and `edge_fall` are registered versions of `cond & ~cond_q` and `~cond & cond_q`. Edge detection always uses the conditioned path, independent of `pin_dir`.
- Bypass: `prop_input_bus[i] = pin_dir[i] ? pin_out[i] : cond[i]`. This is combinational and has zero latency on the output path.
- Reset (`res` = 1 at an edge):
  - All sync, filter, pipeline and `cond_q` flops load `INIT`.
  - All `cnt` load 0.
  - `edge_rise` and `edge_fall` load 0.
  - No spurious edge pulse is generated on reset exit, even if the pin level differs from `INIT`. That transition appears as a normal edge after full latency.
- Reset asserted mid-filter discards any partial count.
- Reset has priority over all other updates.

## Timing
- Output reset values:
  - `edge_rise` and `edge_fall` are 0.
  - `prop_input_bus` is `pin_dir ? pin_out : INIT`.
- Raw-to-`cond` latency, measured as a change stable before edge k, visible after edge k+L−1:
  - Without filter: L = `SYNC_STAGES` + `PIPELINE_STAGES`.
  - With filter: L = `SYNC_STAGES` + `FILTER_LEN` + `PIPELINE_STAGES`.
- Edge pulses assert one cycle after `cond` changes and last exactly one cycle.
- A synchronized glitch shorter than `FILTER_LEN` cycles produces no change on `cond` and no edge.
- The `pin_dir` and `pin_out` bypass takes effect in the same cycle it changes.
- When `pin_dir` falls, `prop_input_bus` immediately shows `cond`. That value reflects the pad as it stood L cycles earlier.

## Configuration
- `PIN_DEGLITCH_EN` defined: the filter is instantiated, and the `FILTER_LEN` cycles are added to latency.
- `PIN_DEGLITCH_EN` undefined: the filter is removed, and the synchronizer feeds the pipeline directly. `FILTER_LEN` is ignored, and no counter logic is synthesized.

## Structure
Shared package `p1v_pin_pkg` holds:
- `localparam NUMPINS = 32`;
- typedef `pin_vec_t` (`logic [NUMPINS-1:0]`);
- the legal parameter bounds, checked by elaboration-time assertions in this block.

One sub-module, `pin_deglitch`, holds the single-bit `filt`/`cnt` logic with parameter `FILTER_LEN`. It is instantiated 32× via generate, only under `PIN_DEGLITCH_EN`.

The rest of the block is flat generate loops at top level.

## Test plan
- Defaults, filter off:
  - Hold `res` 3 cycles, then `pin_in` = 32'h0000_0001 with `pin_dir` = 0.
  - Bit 0 of `prop_input_bus` rises after exactly 4 edges.
  - `edge_rise[0]` pulses one cycle later, exactly one cycle wide.
  - `edge_fall` stays 0.
- Filter on, `FILTER_LEN` = 4:
  - A 3-cycle-wide high pulse on `pin_in[5]` → no change on bit 5 and no edge.
  - A 4-cycle pulse → bit 5 rises after 8 edges, then falls after a further 4.
  - `edge_rise[5]` and `edge_fall[5]` each pulse once.
- Bypass:
  - `pin_dir` = 32'hFFFF_0000 and `pin_out` = 32'hA5A5_0000 while `pin_in` = 0 → `prop_input_bus` = 32'hA5A5_0000 in the same cycle.
  - Clearing `pin_dir` → the upper bits read 0 in the same cycle.
- Reset mid-filter:
  - Assert `res` after 2 of 4 filter cycles with `pin_in` held at 32'hFFFF_FFFF.
  - After release, all bits rise exactly 8 edges later, with no edge pulses during or right after reset.
- `INIT` = 32'hFFFF_FFFF, `pin_in` held high through reset → `prop_input_bus` = 32'hFFFF_FFFF with no `edge_rise` or `edge_fall` pulses ever.
- `PIPELINE_STAGES` = 0, `SYNC_STAGES` = 3, filter off → a toggle on `pin_in[31]` is visible after 3 edges.
